// File: rtl/rd_popcount_seq.sv
// rd_popcount_seq
//   Sequential population counter. It accepts an N-bit vector, then counts its
//   1s K bits per clock over C = ceil(N/K) RUN cycles. It reports the count,
//   an unsigned compare against a captured threshold, and the parity.
//   For N=7 the three count bits are the rd73 weight outputs.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (wins over every handshake)
//   in_valid   source offers in_data/in_thr
//   in_ready   high only in IDLE (depends on the state alone)
//   in_data    N-bit vector to count
//   in_thr     W-bit threshold for out_ge
//   out_valid  result held in DONE until out_ready
//   out_ready  sink accepts the result (ignored outside DONE)
//   out_count  number of 1s in the accepted vector
//   out_ge     out_count >= captured threshold
//   out_parity XOR of the accepted bits (= out_count[0])
module rd_popcount_seq #(
  parameter  int N = 7,
  parameter  int K = 1,
  localparam int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_thr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_count,
  output logic         out_ge,
  output logic         out_parity
);

  localparam int C  = (N + K - 1) / K;
  // Shift register is padded to a whole number of chunks. The pad bits start
  // at zero and only zeros are shifted in, so the last chunk counts correctly.
  localparam int SW = C * K;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [SW-1:0] shift_reg;
  logic [W-1:0]  acc_reg;
  logic [CW-1:0] chunk_cnt_reg;
  logic [W-1:0]  thr_reg;
  logic [W-1:0]  count_reg;
  logic          ge_reg;
  logic          parity_reg;

  logic [W-1:0]  chunk_pop;
  logic [W-1:0]  sum_next;

  // Popcount of the chunk currently in the low K bits.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < K; i++) begin
      chunk_pop = chunk_pop + W'(shift_reg[i]);
    end
  end

  // The accumulator can never exceed N, so W bits always hold the sum.
  assign sum_next = acc_reg + chunk_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      acc_reg       <= '0;
      chunk_cnt_reg <= '0;
      thr_reg       <= '0;
      count_reg     <= '0;
      ge_reg        <= 1'b0;
      parity_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            shift_reg     <= SW'(in_data);
            thr_reg       <= in_thr;
            acc_reg       <= '0;
            chunk_cnt_reg <= CW'(C - 1);
            state_reg     <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_reg   <= sum_next;
          shift_reg <= shift_reg >> K;
          if (chunk_cnt_reg == '0) begin
            // Last chunk: register every result output here, so no input
            // reaches an output through combinational logic.
            count_reg  <= sum_next;
            ge_reg     <= (sum_next >= thr_reg);
            parity_reg <= sum_next[0];
            state_reg  <= ST_DONE;
          end else begin
            chunk_cnt_reg <= chunk_cnt_reg - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == ST_IDLE);
  assign out_valid  = (state_reg == ST_DONE);
  assign out_count  = count_reg;
  assign out_ge     = ge_reg;
  assign out_parity = parity_reg;

endmodule

// File: tb/tb_rd_popcount_seq.sv
// Testbench for rd_popcount_seq. Three builds share the stimulus:
//   index 0: N=7, K=1 (C=7, latency 8)
//   index 1: N=7, K=3 (C=3, latency 4, padded last chunk)
//   index 2: N=8, K=4 (C=2, latency 3, W=4 so in_thr can exceed N)
module tb_rd_popcount_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic [3:0] in_thr;

  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] ge;
  logic [2:0] par;
  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic [3:0] cnt_c;

  int n_checks = 0;
  int n_pass   = 0;
  int lat_exp [3] = '{8, 4, 3};
  logic [3:0] last_cnt [3];
  logic       last_ge  [3];
  logic       last_par [3];

  always #5 clk = ~clk;

  rd_popcount_seq #(.N(7), .K(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data[6:0]), .in_thr(in_thr[2:0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_count(cnt_a), .out_ge(ge[0]), .out_parity(par[0])
  );

  rd_popcount_seq #(.N(7), .K(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data[6:0]), .in_thr(in_thr[2:0]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_count(cnt_b), .out_ge(ge[1]), .out_parity(par[1])
  );

  rd_popcount_seq #(.N(8), .K(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_thr(in_thr), .out_valid(ov[2]),
    .out_ready(out_ready), .out_count(cnt_c), .out_ge(ge[2]), .out_parity(par[2])
  );

  function automatic logic [3:0] cnt_of(input int j);
    case (j)
      0:       return {1'b0, cnt_a};
      1:       return {1'b0, cnt_b};
      default: return cnt_c;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // One transaction on all three builds. If hold is set, out_ready stays low
  // until every build shows a result, then for 10 more cycles.
  task automatic run_vec(input logic [7:0] d, input logic [3:0] t, input bit hold);
    int lat [3];
    int ec, tj, n_max;
    logic [3:0] oc [3];
    logic og [3];
    logic op [3];
    @(negedge clk);
    in_data   = d;
    in_thr    = t;
    in_valid  = 1'b1;
    out_ready = !hold;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("in_ready_idle[%0d]", j), 32'(ir[j]), 32'd1);
      lat[j] = 0;
    end
    n_max = hold ? 9 : 10;
    for (int n = 1; n <= n_max; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (ov[j] && lat[j] == 0) begin
          lat[j] = n;
          oc[j]  = cnt_of(j);
          og[j]  = ge[j];
          op[j]  = par[j];
        end
        if (!hold)
          check($sformatf("in_ready_n%0d[%0d]", n, j), 32'(ir[j]), 32'(n > lat_exp[j]));
      end
    end
    for (int j = 0; j < 3; j++) begin
      ec = 0;
      for (int b = 0; b < ((j == 2) ? 8 : 7); b++) ec += int'(d[b]);
      tj = (j == 2) ? int'(t) : int'(t[2:0]);
      check($sformatf("latency[%0d] d=%02h", j, d), 32'(lat[j]), 32'(lat_exp[j]));
      check($sformatf("count[%0d] d=%02h", j, d), 32'(oc[j]), 32'(ec));
      check($sformatf("ge[%0d] d=%02h t=%0d", j, d, t), 32'(og[j]), 32'(ec >= tj));
      check($sformatf("parity[%0d] d=%02h", j, d), 32'(op[j]), 32'(ec & 1));
      last_cnt[j] = oc[j];
      last_ge[j]  = og[j];
      last_par[j] = op[j];
    end
    if (hold) begin
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          check($sformatf("hold_valid[%0d]", j), 32'(ov[j]), 32'd1);
          check($sformatf("hold_ready[%0d]", j), 32'(ir[j]), 32'd0);
          check($sformatf("hold_count[%0d]", j), 32'(cnt_of(j)), 32'(oc[j]));
          check($sformatf("hold_ge[%0d]", j), 32'(ge[j]), 32'(og[j]));
          check($sformatf("hold_par[%0d]", j), 32'(par[j]), 32'(op[j]));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("release_ready[%0d]", j), 32'(ir[j]), 32'd1);
        check($sformatf("release_valid[%0d]", j), 32'(ov[j]), 32'd0);
      end
    end
    $display("vec d=%02h thr=%0d hold=%0d -> cnt %0d/%0d/%0d ge %0d/%0d/%0d lat %0d/%0d/%0d",
             d, t, hold, last_cnt[0], last_cnt[1], last_cnt[2],
             last_ge[0], last_ge[1], last_ge[2], lat[0], lat[1], lat[2]);
  endtask

  initial begin
    int seen;

    // Reset with in_valid high: nothing may be accepted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_thr    = 4'd1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_ready[%0d]", j), 32'(ir[j]), 32'd1);
      check($sformatf("rst_valid[%0d]", j), 32'(ov[j]), 32'd0);
      check($sformatf("rst_count[%0d]", j), 32'(cnt_of(j)), 32'd0);
      check($sformatf("rst_ge[%0d]", j), 32'(ge[j]), 32'd0);
      check($sformatf("rst_par[%0d]", j), 32'(par[j]), 32'd0);
    end

    // Basic case 7'b1010101, thr 4: count 4, ge 1, parity 0.
    run_vec(8'h55, 4'd4, 1'b0);
    check("basic_count", 32'(last_cnt[0]), 32'd4);
    check("basic_ge", 32'(last_ge[0]), 32'd1);
    check("basic_par", 32'(last_par[0]), 32'd0);

    // All-ones with thr 7 on the padded K=3 build: count 7, ge 1, parity 1.
    run_vec(8'h7F, 4'd7, 1'b0);
    check("pad_count", 32'(last_cnt[1]), 32'd7);
    check("pad_ge", 32'(last_ge[1]), 32'd1);
    check("pad_par", 32'(last_par[1]), 32'd1);

    // Threshold edges.
    run_vec(8'h00, 4'd0, 1'b0);
    check("thr0_ge", 32'(last_ge[0]), 32'd1);
    check("thr0_count", 32'(last_cnt[0]), 32'd0);
    run_vec(8'h7F, 4'd8, 1'b0);
    check("thr8_ge_n8", 32'(last_ge[2]), 32'd0);
    check("thr8_count_n8", 32'(last_cnt[2]), 32'd7);
    run_vec(8'hFF, 4'd15, 1'b0);
    check("thr15_ge_n8", 32'(last_ge[2]), 32'd0);
    check("ff_count_n8", 32'(last_cnt[2]), 32'd8);

    // Backpressure: out_ready low for 10 cycles after out_valid.
    run_vec(8'h2B, 4'd3, 1'b1);

    // Exhaustive sweep of 7-bit vectors at thr 4.
    for (int v = 0; v < 128; v++) begin
      run_vec(8'(v), 4'd4, 1'b0);
      check($sformatf("ge_is_bit2 v=%0d", v), 32'(last_ge[0]), 32'(last_cnt[0][2]));
    end

    // Reset pulsed on the third RUN cycle: the vector must vanish.
    @(negedge clk);
    in_data   = 8'h7F;
    in_thr    = 4'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("midrst_ready[%0d]", j), 32'(ir[j]), 32'd1);
      check($sformatf("midrst_valid[%0d]", j), 32'(ov[j]), 32'd0);
      check($sformatf("midrst_count[%0d]", j), 32'(cnt_of(j)), 32'd0);
      check($sformatf("midrst_ge[%0d]", j), 32'(ge[j]), 32'd0);
      check($sformatf("midrst_par[%0d]", j), 32'(par[j]), 32'd0);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov != 3'b000) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    $display("reset mid-run: valid cycles seen afterwards %0d", seen);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rd_popcount_seq.md
RD_POPCOUNT_SEQ -- requirements
Module: rd_popcount_seq

Interface
REQ-001 SHALL expose parameter N, default 7, meaning input vector width in bits (N >= 1).
REQ-002 SHALL expose parameter K, default 1, meaning bits consumed per RUN cycle (1 <= K <= N).
REQ-003 SHALL derive localparam W = clog2(N+1), meaning the result width, and C = ceil(N/K), meaning the RUN cycle count.
REQ-004 SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have the port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have the port in_valid, input, 1 bit, source offers a vector.
REQ-007 SHALL have the port in_ready, output, 1 bit, block can accept a vector.
REQ-008 SHALL have the port in_data, input, N bits, vector to count (bit i = xi).
REQ-009 SHALL have the port in_thr, input, W bits, threshold for the out_ge comparison.
REQ-010 SHALL have the port out_valid, output, 1 bit, result available.
REQ-011 SHALL have the port out_ready, input, 1 bit, sink accepts the result.
REQ-012 SHALL have the port out_count, output, W bits, number of 1s in the accepted vector.
REQ-013 SHALL have the port out_ge, output, 1 bit, out_count >= captured threshold (unsigned).
REQ-014 SHALL have the port out_parity, output, 1 bit, XOR of all accepted bits (out_count[0]).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; in_ready is combinational from the state only, never from in_valid.
REQ-017 SHALL, on in_valid && in_ready in IDLE, capture in_data into a shift register and in_thr into a threshold register, clear the accumulator, load the chunk counter with C-1, and enter RUN.
REQ-018 SHALL, in each RUN cycle, add popcount of the low K bits of the shift register to the accumulator, then shift right by K with zero fill.
REQ-019 SHALL zero-pad the final chunk when N mod K != 0; padded bits contribute 0.
REQ-020 SHALL keep the accumulator W bits wide; overflow is impossible by construction and no saturation logic is needed.
REQ-021 SHALL leave RUN for DONE after exactly C RUN cycles; out_valid rises on the clock edge following the last RUN cycle.
REQ-022 SHALL give a latency of C+1 cycles from the accept edge to out_valid=1 (N=7, K=1: 8 cycles; N=7, K=7: 2 cycles).
REQ-023 SHALL, in DONE, hold out_valid=1 and keep out_count, out_ge, out_parity stable until out_ready=1.
REQ-024 SHALL, on out_valid && out_ready, return to IDLE on that edge; a new vector is accepted no earlier than the next cycle (throughput: one vector per C+2 cycles minimum).
REQ-025 SHALL ignore in_valid, in_data and in_thr in RUN and DONE, and ignore out_ready outside DONE.
REQ-026 SHALL register out_ge and out_parity at the transition to DONE (no combinational path from inputs to outputs).
REQ-027 SHALL handle in_thr=0 by forcing out_ge=1, and in_thr > N by forcing out_ge=0 for all vectors.
REQ-028 SHALL, for N=7, have out_count[2], out_count[1] and out_count[0] equal the three weight bits of the rd73 function, with out_count[2] = (count >= 4).

Reset
REQ-029 SHALL, while rst=1 at a clock edge, enter IDLE and clear the shift register, accumulator, chunk counter, threshold register, out_count, out_ge and out_parity to 0.
REQ-030 SHALL, after reset, drive out_valid=0 and in_ready=1 from the first cycle with rst=0.
REQ-031 SHALL give rst priority over every handshake; a reset asserted in RUN or DONE discards the in-flight vector and no result is emitted for it.
REQ-032 SHALL not accept a vector on a cycle where rst=1, even if in_valid=1.

Verification
REQ-033 SHALL cover the basic case: N=7, K=1, in_data=7'b1010101, in_thr=4, out_ready=1 -> out_valid high 8 cycles after accept, out_count=4, out_ge=1, out_parity=0.
REQ-034 SHALL cover exhaustive checking: N=7, K=1, all 128 vectors, in_thr=4 -> out_count equals the reference popcount and out_ge equals out_count[2] for every vector.
REQ-035 SHALL cover padding and throughput: N=7, K=3 (C=3), in_data=7'b1111111, in_thr=7 -> out_count=7, out_ge=1, out_parity=1, latency 4 cycles; back-to-back vectors are spaced at least 5 cycles apart.
REQ-036 SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid rises -> outputs stable and in_ready=0 throughout; release -> IDLE the next cycle with in_ready=1.
REQ-037 SHALL cover reset mid-operation: rst pulsed on the 3rd RUN cycle -> out_valid never rises for that vector, in_ready=1 the cycle after rst falls, all outputs 0.
REQ-038 SHALL cover threshold edges: in_data=0, in_thr=0 -> out_ge=1, out_count=0; in_data=7'h7F, in_thr=7'd8 (W=3 truncation excluded, N=8 build) -> out_ge=0.
